handshake_rx_multi: RTL and testbench
=====================================

Name: handshake_rx_multi

Overview:
- Parametrised successor to the single-channel 4-phase handshake receiver. Terminates NUM_CH independent asynchronous req/ack producers, such as Pico GPIO channels.
- Each channel has its own synchroniser, a configurable data-settle delay and a capture buffer.
- Captured words are round-robin merged onto one valid/ready stream, tagged with the channel index.
- ack is raised only when the word enters the output register, so downstream back-pressure stalls producers and no data is lost.

Parameters:
- DATA_WIDTH, 4, bits per channel word.
- NUM_CH, 2, number of producer channels, 1..16.
- SYNC_STAGES, 2, synchroniser flops on each req, 2..4.
- SETTLE_CYCLES, 1, cycles between synchronised req rise and data capture, 0..15.
- TIMEOUT_CYCLES, 1024, ack-high limit; used only with HS_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- req  in  NUM_CH  asynchronous request, one bit per channel.
- data  in  NUM_CH*DATA_WIDTH  channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
- ack  out  NUM_CH  registered acknowledge per channel.
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accepts the word when out_valid && out_ready.
- out_data  out  DATA_WIDTH  captured word.
- out_ch  out  CH_W  source channel; CH_W = max(1, $clog2(NUM_CH)).
- err  out  NUM_CH  sticky timeout flag per channel; tied to 0 without HS_TIMEOUT_EN.

Behaviour:
Reset
- While reset_n is low at a clk edge: synchronisers clear; every channel FSM goes to IDLE; settle counters, ack, out_valid, out_data, out_ch and err all clear to 0; round-robin pointer is set to 0.
- Reset mid-transaction drops ack immediately. A req still high after reset is treated as a new transaction.

Per-channel FSM (state, next state)
- IDLE: if synchronised req (req_s) is 1 → SETTLE with counter loaded to SETTLE_CYCLES-1. When SETTLE_CYCLES = 0, capture data directly → HOLD.
- SETTLE: counter decrements each cycle; at 0, register the raw data slice into the channel buffer → HOLD. If req_s falls during SETTLE → IDLE, nothing captured (glitch reject).
- HOLD: waits for a grant. On grant → ACK_HI, ack[c] set to 1.
- ACK_HI: when req_s = 0 → IDLE, ack[c] cleared to 0.
- Unreachable encodings → IDLE.

Output arbiter
- The output register loads when (!out_valid || out_ready) and at least one channel is in HOLD.
- Grant goes to the first HOLD channel at or after the pointer, scanning upward with wrap. The pointer then moves to granted+1, modulo NUM_CH.
- On load: out_valid=1, out_data=buffer, out_ch=index, ack[index]=1, all on the same edge.
- Accept and load in the same cycle is allowed, giving one word per cycle throughput.
- out_valid clears only on accept with no new load.
- out_data and out_ch stay stable while out_valid && !out_ready.

Latency
- Let edge E be the first edge at which req is sampled high. For an uncontested channel with a free output, out_valid and ack rise at edge E+SYNC_STAGES+SETTLE_CYCLES+1.
- With default parameters this is E+4.

Boundary conditions
- A producer dropping req before ack gets the glitch rule in SETTLE. In HOLD the captured word is still delivered; ack then pulses for one cycle.
- Concurrent requests from all channels are each served within NUM_CH output transfers.

Optional Feature:
HS_TIMEOUT_EN
- Defined:
  - Each channel counts cycles spent in ACK_HI.
  - When the count reaches TIMEOUT_CYCLES with req_s still 1: ack[c] goes to 0, err[c] is set (sticky until reset), and the FSM enters STUCK.
  - STUCK → IDLE once req_s = 0.
  - The already delivered word is unaffected.
- Undefined: no counters and no STUCK state; err is constant 0; ACK_HI waits indefinitely.

Test Plan:
1. NUM_CH=2, defaults, out_ready=1; ch0 data=4'hA, req rises → out_valid, out_ch=0, out_data=A and ack[0] rise 4 edges later; req falls → ack[0] low 2–3 edges later.
2. req[0] and req[1] rise on the same edge with data 3 and 5 → out_ch sequence 0 then 1 on consecutive cycles; next simultaneous pair gives 0,1 again (pointer wrap).
3. out_ready=0 for 20 cycles, ch1 requests → out_valid held with data stable, ack[1] held 0 while ch1 sits in HOLD until the register frees; second word delivered with no loss.
4. req[0] pulse of 2 cycles with SETTLE_CYCLES=3 → no out_valid, ack stays 0.
5. reset_n low for 1 cycle while ack[0]=1 and out_valid=1 → next cycle all outputs 0; req[0] still high gives a fresh capture.
6. HS_TIMEOUT_EN, TIMEOUT_CYCLES=16, req[1] held high → ack[1] drops after 16 cycles, err[1]=1; err stays 1 after req falls; the next request is served normally.

Source files
------------

// File: rtl/handshake_rx_multi.sv
// NUM_CH-channel 4-phase req/ack receiver; captured words are round-robin merged onto one valid/ready stream.
// Optional per-channel ack-high timeout with sticky err flag: define HS_TIMEOUT_EN.
module handshake_rx_multi #(
   parameter int DATA_WIDTH     = 4,
   parameter int NUM_CH         = 2,
   parameter int SYNC_STAGES    = 2,
   parameter int SETTLE_CYCLES  = 1,
   parameter int TIMEOUT_CYCLES = 1024,
   localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [NUM_CH-1:0]            req,
   input  logic [NUM_CH*DATA_WIDTH-1:0] data,
   output logic [NUM_CH-1:0]            ack,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DATA_WIDTH-1:0]        out_data,
   output logic [CH_W-1:0]              out_ch,
   output logic [NUM_CH-1:0]            err
);

   // state     | meaning
   // ----------+---------------------------------------------------------
   // ST_IDLE   | waiting for synchronised req
   // ST_SETTLE | req seen, counting down data-settle delay
   // ST_HOLD   | word captured in channel buffer, waiting for output grant
   // ST_ACK_HI | word delivered, ack high, waiting for req to fall
   // ST_STUCK  | ack timed out with req still high (HS_TIMEOUT_EN only)
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETTLE = 3'd1,
      ST_HOLD   = 3'd2,
      ST_ACK_HI = 3'd3
`ifdef HS_TIMEOUT_EN
      , ST_STUCK = 3'd4
`endif
   } state_t;

   if (NUM_CH < 1 || NUM_CH > 16) begin : g_chk_ch
      $error("handshake_rx_multi: NUM_CH must be 1..16");
   end
   if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_chk_sync
      $error("handshake_rx_multi: SYNC_STAGES must be 2..4");
   end
   if (SETTLE_CYCLES < 0 || SETTLE_CYCLES > 15) begin : g_chk_settle
      $error("handshake_rx_multi: SETTLE_CYCLES must be 0..15");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_chk_timeout
      $error("handshake_rx_multi: TIMEOUT_CYCLES must be at least 1");
   end
   if (DATA_WIDTH < 1) begin : g_chk_dw
      $error("handshake_rx_multi: DATA_WIDTH must be at least 1");
   end

   localparam logic [3:0] SETTLE_LOAD = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;

   state_t                  state_q [NUM_CH];
   state_t                  state_d [NUM_CH];
   logic [SYNC_STAGES-1:0]  sync_q  [NUM_CH];
   logic [3:0]              cnt_q   [NUM_CH];
   logic [DATA_WIDTH-1:0]   buf_q   [NUM_CH];
   logic [NUM_CH-1:0]       req_s;
   logic [NUM_CH-1:0]       hold;
   logic [NUM_CH-1:0]       grant;
   logic [NUM_CH-1:0]       cap_en;
   logic [NUM_CH-1:0]       cnt_load;
   logic [NUM_CH-1:0]       cnt_dec;
   logic [NUM_CH-1:0]       ack_d;
   logic [NUM_CH-1:0]       ack_q;
   logic                    load;
   logic                    found;
   logic [CH_W-1:0]         gnt_idx;
   logic [CH_W-1:0]         ptr_q;
   logic [CH_W-1:0]         ptr_d;

`ifdef HS_TIMEOUT_EN
   localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0]           tmr_q [NUM_CH];
   logic [NUM_CH-1:0]       tmr_load;
   logic [NUM_CH-1:0]       tmr_dec;
   logic [NUM_CH-1:0]       err_set;
   logic [NUM_CH-1:0]       err_q;
`endif

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         req_s[c] = sync_q[c][SYNC_STAGES-1];
         hold[c]  = (state_q[c] == ST_HOLD);
      end
   end

   // State register and req synchronisers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int c = 0; c < NUM_CH; c++) begin
            state_q[c] <= ST_IDLE;
            sync_q[c]  <= '0;
         end
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            state_q[c] <= state_d[c];
            sync_q[c]  <= {sync_q[c][SYNC_STAGES-2:0], req[c]};
         end
      end
   end

   // Next-state logic
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         state_d[c] = state_q[c];
         case (state_q[c])
            ST_IDLE: begin
               if (req_s[c]) begin
                  if (SETTLE_CYCLES == 0) state_d[c] = ST_HOLD;
                  else                    state_d[c] = ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (!req_s[c])              state_d[c] = ST_IDLE;
               else if (cnt_q[c] == 4'd0)  state_d[c] = ST_HOLD;
            end
            ST_HOLD: begin
               if (grant[c]) state_d[c] = ST_ACK_HI;
            end
            ST_ACK_HI: begin
               if (!req_s[c]) state_d[c] = ST_IDLE;
`ifdef HS_TIMEOUT_EN
               else if (tmr_q[c] == '0) state_d[c] = ST_STUCK;
`endif
            end
`ifdef HS_TIMEOUT_EN
            ST_STUCK: begin
               if (!req_s[c]) state_d[c] = ST_IDLE;
            end
`endif
            default: state_d[c] = ST_IDLE;
         endcase
      end
   end

   // Per-channel control outputs
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         cap_en[c]   = (state_d[c] == ST_HOLD) && (state_q[c] != ST_HOLD);
         cnt_load[c] = (state_q[c] == ST_IDLE);
         cnt_dec[c]  = (state_q[c] == ST_SETTLE) && (cnt_q[c] != 4'd0);
         ack_d[c]    = (state_d[c] == ST_ACK_HI);
`ifdef HS_TIMEOUT_EN
         tmr_load[c] = (state_d[c] == ST_ACK_HI) && (state_q[c] != ST_ACK_HI);
         tmr_dec[c]  = (state_q[c] == ST_ACK_HI) && (tmr_q[c] != '0);
         err_set[c]  = (state_q[c] == ST_ACK_HI) && (state_d[c] == ST_STUCK);
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int c = 0; c < NUM_CH; c++) begin
            cnt_q[c] <= 4'd0;
            buf_q[c] <= '0;
            ack_q[c] <= 1'b0;
         end
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (cnt_load[c])     cnt_q[c] <= SETTLE_LOAD;
            else if (cnt_dec[c]) cnt_q[c] <= cnt_q[c] - 4'd1;
            if (cap_en[c]) buf_q[c] <= data[c*DATA_WIDTH +: DATA_WIDTH];
            ack_q[c] <= ack_d[c];
         end
      end
   end

`ifdef HS_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int c = 0; c < NUM_CH; c++) begin
            tmr_q[c] <= '0;
            err_q[c] <= 1'b0;
         end
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (tmr_load[c])     tmr_q[c] <= TO_LOAD;
            else if (tmr_dec[c]) tmr_q[c] <= tmr_q[c] - TW'(1);
            if (err_set[c]) err_q[c] <= 1'b1;
         end
      end
   end

   assign err = err_q;
`else
   assign err = '0;
`endif

   // Round-robin scan: first HOLD channel at or after ptr_q, wrapping
   always_comb begin
      int j;
      int p;
      j       = 0;
      p       = 0;
      found   = 1'b0;
      gnt_idx = '0;
      grant   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         j = int'(ptr_q) + i;
         if (j >= NUM_CH) j = j - NUM_CH;
         if (!found && hold[CH_W'(j)]) begin
            found   = 1'b1;
            gnt_idx = CH_W'(j);
         end
      end
      load = (!out_valid || out_ready) && found;
      if (load) grant[gnt_idx] = 1'b1;
      p = int'(gnt_idx) + 1;
      if (p >= NUM_CH) p = 0;
      ptr_d = CH_W'(p);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         ptr_q     <= '0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= buf_q[gnt_idx];
         out_ch    <= gnt_idx;
         ptr_q     <= ptr_d;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   assign ack = ack_q;

endmodule

// File: tb/tb_handshake_rx_multi.sv
// Bench for handshake_rx_multi: per-cycle vector table, per-channel scoreboard and hand-written corner sequences.
module tb_handshake_rx_multi;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [1:0] req;
   logic [7:0] data;
   logic [1:0] ack;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_data;
   logic [0:0] out_ch;
   logic [1:0] err;

   logic [1:0] req3;
   logic [7:0] data3;
   logic [1:0] ack3;
   logic       v3;
   logic       rdy3;
   logic [3:0] d3;
   logic [0:0] ch3;
   logic [1:0] err3;

   int n_cmp = 0;
   int n_bad = 0;

   logic [3:0] sbq0[$];
   logic [3:0] sbq1[$];
   logic [3:0] sb_exp;

   typedef struct packed {
      logic [1:0] req;
      logic [3:0] d0;
      logic [3:0] d1;
      logic       rdy;
      logic       v;
      logic       ch;
      logic [3:0] dat;
      logic [1:0] ack;
   } vec_t;

   localparam int NV = 29;
   vec_t vec [NV];

   always #5 clk = ~clk;

   handshake_rx_multi #(
      .DATA_WIDTH(4), .NUM_CH(2), .SYNC_STAGES(2), .SETTLE_CYCLES(1), .TIMEOUT_CYCLES(16)
   ) u_dut (
      .clk(clk), .reset_n(reset_n), .req(req), .data(data), .ack(ack),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch), .err(err)
   );

   handshake_rx_multi #(
      .DATA_WIDTH(4), .NUM_CH(2), .SYNC_STAGES(2), .SETTLE_CYCLES(3), .TIMEOUT_CYCLES(1024)
   ) u_dut3 (
      .clk(clk), .reset_n(reset_n), .req(req3), .data(data3), .ack(ack3),
      .out_valid(v3), .out_ready(rdy3), .out_data(d3), .out_ch(ch3), .err(err3)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic wait_valid(input string nm, input int budget);
      int n;
      n = 0;
      while (out_valid !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      n_cmp++;
      if (out_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL %s: out_valid=%b after %0d cycles, expected 1", nm, out_valid, budget);
      end
   endtask

   function automatic vec_t mk(input logic [1:0] r, input logic [3:0] a, input logic [3:0] b,
                               input logic rd, input logic v, input logic ch,
                               input logic [3:0] dat, input logic [1:0] ak);
      vec_t t;
      t.req = r; t.d0 = a; t.d1 = b; t.rdy = rd;
      t.v = v; t.ch = ch; t.dat = dat; t.ack = ak;
      return t;
   endfunction

   // Scoreboard: a word leaves when valid && ready at the coming edge
   always @(negedge clk) begin
      if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (out_ch === 1'b0) begin
            if (sbq0.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL sb ch0: got unexpected word %0h, expected none", out_data);
            end else begin
               sb_exp = sbq0.pop_front();
               chk("sb ch0 data", 32'(out_data), 32'(sb_exp));
            end
         end else begin
            if (sbq1.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL sb ch1: got unexpected word %0h, expected none", out_data);
            end else begin
               sb_exp = sbq1.pop_front();
               chk("sb ch1 data", 32'(out_data), 32'(sb_exp));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] prev;
      int bad;
      int hi;

      reset_n = 1'b0; req = '0; data = '0; out_ready = 1'b1;
      req3 = '0; data3 = '0; rdy3 = 1'b1;
      repeat (3) tick();
      chk("rst out_valid", 32'(out_valid), 0);
      chk("rst ack", 32'(ack), 0);
      chk("rst out_data", 32'(out_data), 0);
      chk("rst out_ch", 32'(out_ch), 0);
      chk("rst err", 32'(err), 0);
      chk("rst u3 valid/ack", {v3, ack3}, 0);
      reset_n = 1'b1;
      tick();

      // Simultaneous pair (3,5), second pair (9,6) after pointer wrap, then single ch0 word A
      for (int i = 0; i < 4; i++) vec[i] = mk(2'b11, 4'h3, 4'h5, 1, 0, 0, 4'h0, 2'b00);
      vec[4]  = mk(2'b11, 4'h3, 4'h5, 1, 1, 0, 4'h3, 2'b01);
      vec[5]  = mk(2'b11, 4'h3, 4'h5, 1, 1, 1, 4'h5, 2'b11);
      vec[6]  = mk(2'b11, 4'h3, 4'h5, 1, 0, 1, 4'h5, 2'b11);
      vec[7]  = mk(2'b00, 4'h3, 4'h5, 1, 0, 1, 4'h5, 2'b11);
      vec[8]  = mk(2'b00, 4'h3, 4'h5, 1, 0, 1, 4'h5, 2'b11);
      vec[9]  = mk(2'b00, 4'h3, 4'h5, 1, 0, 1, 4'h5, 2'b00);
      for (int i = 10; i < 14; i++) vec[i] = mk(2'b11, 4'h9, 4'h6, 1, 0, 1, 4'h5, 2'b00);
      vec[14] = mk(2'b11, 4'h9, 4'h6, 1, 1, 0, 4'h9, 2'b01);
      vec[15] = mk(2'b11, 4'h9, 4'h6, 1, 1, 1, 4'h6, 2'b11);
      vec[16] = mk(2'b11, 4'h9, 4'h6, 1, 0, 1, 4'h6, 2'b11);
      vec[17] = mk(2'b00, 4'h9, 4'h6, 1, 0, 1, 4'h6, 2'b11);
      vec[18] = mk(2'b00, 4'h9, 4'h6, 1, 0, 1, 4'h6, 2'b11);
      vec[19] = mk(2'b00, 4'h9, 4'h6, 1, 0, 1, 4'h6, 2'b00);
      for (int i = 20; i < 24; i++) vec[i] = mk(2'b01, 4'hA, 4'h6, 1, 0, 1, 4'h6, 2'b00);
      vec[24] = mk(2'b01, 4'hA, 4'h6, 1, 1, 0, 4'hA, 2'b01);
      vec[25] = mk(2'b01, 4'hA, 4'h6, 1, 0, 0, 4'hA, 2'b01);
      vec[26] = mk(2'b00, 4'hA, 4'h6, 1, 0, 0, 4'hA, 2'b01);
      vec[27] = mk(2'b00, 4'hA, 4'h6, 1, 0, 0, 4'hA, 2'b01);
      vec[28] = mk(2'b00, 4'hA, 4'h6, 1, 0, 0, 4'hA, 2'b00);

      prev = 2'b00;
      for (int i = 0; i < NV; i++) begin
         req = vec[i].req;
         data = {vec[i].d1, vec[i].d0};
         out_ready = vec[i].rdy;
         if (vec[i].req[0] && !prev[0]) sbq0.push_back(vec[i].d0);
         if (vec[i].req[1] && !prev[1]) sbq1.push_back(vec[i].d1);
         prev = vec[i].req;
         tick();
         chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vec[i].v));
         chk($sformatf("vec%0d out_ch", i), 32'(out_ch), 32'(vec[i].ch));
         chk($sformatf("vec%0d out_data", i), 32'(out_data), 32'(vec[i].dat));
         chk($sformatf("vec%0d ack", i), 32'(ack), 32'(vec[i].ack));
      end

      // Back-pressure: word C parked, ch1 must wait in HOLD without ack
      out_ready = 1'b0; req = 2'b01; data = {4'h0, 4'hC};
      sbq0.push_back(4'hC);
      wait_valid("t3 first word", 10);
      chk("t3 first ch", 32'(out_ch), 0);
      chk("t3 first data", 32'(out_data), 32'hC);
      chk("t3 first ack", 32'(ack), 32'b01);
      req = 2'b11; data = {4'h7, 4'hC};
      sbq1.push_back(4'h7);
      bad = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (out_valid !== 1'b1 || out_data !== 4'hC || out_ch !== 1'b0 || ack[1] !== 1'b0) bad++;
      end
      chk("t3 stall cycles with bad outputs", 32'(bad), 0);
      out_ready = 1'b1;
      tick();
      chk("t3 second valid", 32'(out_valid), 1);
      chk("t3 second ch", 32'(out_ch), 1);
      chk("t3 second data", 32'(out_data), 32'h7);
      chk("t3 second ack", 32'(ack), 32'b11);
      tick();
      chk("t3 drained valid", 32'(out_valid), 0);
      req = 2'b00;
      repeat (4) tick();
      chk("t3 ack released", 32'(ack), 0);

      // Glitch reject on the SETTLE_CYCLES=3 instance, then a normal request there
      req3 = 2'b01; data3 = {4'h0, 4'hD};
      tick(); tick();
      req3 = 2'b00;
      bad = 0;
      repeat (12) begin
         tick();
         if (v3 !== 1'b0 || ack3 !== 2'b00) bad++;
      end
      chk("t4 glitch cycles with output", 32'(bad), 0);
      req3 = 2'b01; data3 = {4'h0, 4'hB};
      repeat (6) tick();
      chk("t4 settle3 valid at E+5", 32'(v3), 0);
      tick();
      chk("t4 settle3 valid at E+6", 32'(v3), 1);
      chk("t4 settle3 data", 32'(d3), 32'hB);
      chk("t4 settle3 ack", 32'(ack3), 32'b01);
      req3 = 2'b00;
      repeat (4) tick();
      chk("t4 settle3 ack released", 32'(ack3), 0);

      // Reset mid-transaction, req held: fresh capture afterwards
      out_ready = 1'b0; req = 2'b01; data = {4'h0, 4'hE};
      wait_valid("t5 before reset", 10);
      chk("t5 ack before reset", 32'(ack), 32'b01);
      reset_n = 1'b0;
      tick();
      sbq0.delete();
      sbq1.delete();
      chk("t5 rst valid", 32'(out_valid), 0);
      chk("t5 rst ack", 32'(ack), 0);
      chk("t5 rst data", 32'(out_data), 0);
      chk("t5 rst ch", 32'(out_ch), 0);
      chk("t5 rst err", 32'(err), 0);
      reset_n = 1'b1; data = {4'h0, 4'h2}; out_ready = 1'b1;
      sbq0.push_back(4'h2);
      repeat (4) tick();
      chk("t5 valid at E+3", 32'(out_valid), 0);
      tick();
      chk("t5 valid at E+4", 32'(out_valid), 1);
      chk("t5 data", 32'(out_data), 32'h2);
      chk("t5 ch", 32'(out_ch), 0);
      chk("t5 ack", 32'(ack), 32'b01);
      req = 2'b00;
      repeat (4) tick();
      chk("t5 ack released", 32'(ack), 0);

      // req[1] held high after delivery
      out_ready = 1'b1; req = 2'b10; data = {4'h8, 4'h0};
      sbq1.push_back(4'h8);
      wait_valid("t6 first", 10);
      chk("t6 ack rise", 32'(ack), 32'b10);
`ifdef HS_TIMEOUT_EN
      hi = 1;
      for (int k = 0; k < 40 && ack[1] === 1'b1; k++) begin
         tick();
         if (ack[1] === 1'b1) hi++;
      end
      chk("t6 ack high cycles", 32'(hi), 16);
      chk("t6 err set", 32'(err), 32'b10);
      req = 2'b00;
      repeat (5) tick();
      chk("t6 err sticky", 32'(err), 32'b10);
      chk("t6 ack low", 32'(ack), 0);
      req = 2'b10; data = {4'h3, 4'h0};
      sbq1.push_back(4'h3);
      wait_valid("t6 after timeout", 10);
      chk("t6 new ack", 32'(ack), 32'b10);
      req = 2'b00;
      repeat (4) tick();
      chk("t6 new ack released", 32'(ack), 0);
      chk("t6 err still sticky", 32'(err), 32'b10);
`else
      hi = 0;
      bad = 0;
      repeat (40) begin
         tick();
         if (ack[1] !== 1'b1) bad++;
         if (err !== 2'b00) hi++;
      end
      chk("t6 ack dropped while req held", 32'(bad), 0);
      chk("t6 err cycles nonzero", 32'(hi), 0);
      req = 2'b00;
      repeat (4) tick();
      chk("t6 ack released", 32'(ack), 0);
`endif

      repeat (2) tick();
      chk("sb ch0 leftover", 32'(sbq0.size()), 0);
      chk("sb ch1 leftover", 32'(sbq1.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
